// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 64-bit, 4-beat burst interface.
// Line-organised storage; fixed request-to-first-beat latency.
module burst_mem_responder #(
  parameter int IDX_WIDTH = 8,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic [63:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err
);

  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LINES = 2 ** IDX_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST,
    ST_DONE
  } state_t;

  state_t               r_state;
  logic                 r_isWrite;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [LAT_W-1:0]     r_latCnt;
  logic [1:0]           r_beat;
  logic                 r_resp;
  logic [63:0]          r_rdata;
  logic                 r_protoErr;
  logic [255:0]         r_mem [LINES];

  logic        w_reqHeld;
  logic        w_memWe;
  logic [1:0]  w_nextBeat;
  logic [63:0] w_curBeatData;
  logic [63:0] w_nextBeatData;
  logic        w_unusedAddr;

  // Only the op latched at acceptance keeps the burst alive; a switch of op counts as a drop.
  assign w_reqHeld      = r_isWrite ? mem_write : mem_read;
  assign w_nextBeat     = r_beat + 2'd1;
  assign w_curBeatData  = r_mem[r_idx][{r_beat, 6'b0} +: 64];
  assign w_nextBeatData = r_mem[r_idx][{w_nextBeat, 6'b0} +: 64];
  assign w_unusedAddr   = ^{mem_addr[31:5+IDX_WIDTH], mem_addr[4:0]};

  // Write data is taken at the end of each cycle in which mem_resp is visible.
  assign w_memWe = reset_n && (r_state == ST_BURST) && r_resp && r_isWrite && w_reqHeld;

  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[r_idx][{r_beat, 6'b0} +: 64] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_isWrite  <= 1'b0;
      r_idx      <= '0;
      r_latCnt   <= '0;
      r_beat     <= 2'd0;
      r_resp     <= 1'b0;
      r_rdata    <= '0;
      r_protoErr <= 1'b0;
    end else begin
      r_protoErr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_resp  <= 1'b0;
          r_rdata <= '0;
          if (mem_read && mem_write) begin
            r_protoErr <= 1'b1;
          end else if (mem_read || mem_write) begin
            r_isWrite <= mem_write;
            r_idx     <= mem_addr[5 +: IDX_WIDTH];
            r_latCnt  <= LAT_W'(LATENCY - 1);
            r_beat    <= 2'd0;
            r_state   <= (LATENCY == 1) ? ST_BURST : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!w_reqHeld) begin
            r_state    <= ST_IDLE;
            r_protoErr <= 1'b1;
          end else begin
            r_latCnt <= r_latCnt - LAT_W'(1);
            if (r_latCnt <= LAT_W'(1)) begin
              r_state <= ST_BURST;
            end
          end
        end
        ST_BURST: begin
          // r_beat names the beat currently shown on mem_resp/mem_rdata.
          if (!w_reqHeld) begin
            r_state    <= ST_IDLE;
            r_resp     <= 1'b0;
            r_rdata    <= '0;
            r_protoErr <= 1'b1;
          end else if (!r_resp) begin
            r_resp  <= 1'b1;
            r_rdata <= r_isWrite ? 64'd0 : w_curBeatData;
          end else if (r_beat == 2'd3) begin
            r_resp  <= 1'b0;
            r_rdata <= '0;
            r_state <= ST_DONE;
          end else begin
            r_beat  <= w_nextBeat;
            r_rdata <= r_isWrite ? 64'd0 : w_nextBeatData;
          end
        end
        ST_DONE: begin
          r_resp  <= 1'b0;
          r_rdata <= '0;
          if (!mem_read && !mem_write) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_resp  = r_resp;
  assign mem_rdata = r_rdata;
  assign proto_err = r_protoErr;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: one LATENCY=4 instance and one LATENCY=1 instance.
module tb_burst_mem_responder;

  localparam int IDXW = 8;

  logic        clk = 1'b0;
  logic        resetN;
  logic        memRead  [2];
  logic        memWrite [2];
  logic [31:0] memAddr  [2];
  logic [63:0] memWdata [2];
  logic [63:0] memRdata [2];
  logic        memResp  [2];
  logic        protoErr [2];

  int testsRun = 0;
  int testsFailed = 0;

  logic [63:0]  expQ[$];
  logic [255:0] model [2][256];

  always #5 clk = ~clk;

  burst_mem_responder #(.IDX_WIDTH(IDXW), .LATENCY(4)) dut0 (
    .clk(clk), .reset_n(resetN),
    .mem_read(memRead[0]), .mem_write(memWrite[0]),
    .mem_addr(memAddr[0]), .mem_wdata(memWdata[0]),
    .mem_rdata(memRdata[0]), .mem_resp(memResp[0]), .proto_err(protoErr[0])
  );

  burst_mem_responder #(.IDX_WIDTH(IDXW), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(resetN),
    .mem_read(memRead[1]), .mem_write(memWrite[1]),
    .mem_addr(memAddr[1]), .mem_wdata(memWdata[1]),
    .mem_rdata(memRdata[1]), .mem_resp(memResp[1]), .proto_err(protoErr[1])
  );

  function automatic int latOf(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [255:0] randLine();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one burst starting at a negedge; dropAt < 4 releases the request when that beat appears.
  task automatic doBurst(input int d, input bit isWrite, input logic [31:0] addr,
                         input logic [255:0] data, input int dropAt);
    int idx;
    int beat;
    int cyc;
    bit done;
    logic [63:0] expBeat;
    idx  = (addr >> 5) % 256;
    beat = 0;
    cyc  = 0;
    done = 1'b0;
    if (!isWrite) begin
      for (int k = 0; k < dropAt && k < 4; k++) expQ.push_back(model[d][idx][64*k +: 64]);
    end
    memAddr[d]  = addr;
    memRead[d]  = !isWrite;
    memWrite[d] = isWrite;
    memWdata[d] = '0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      testsRun++;
      if (protoErr[d] !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL dut%0d proto_err_in_burst: got %b expected 0", d, protoErr[d]);
      end
      if (beat > 0) begin
        testsRun++;
        if (memResp[d] !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL dut%0d resp_consecutive beat %0d: got %b expected 1", d, beat, memResp[d]);
        end
      end
      if (memResp[d] === 1'b1) begin
        if (beat == 0) begin
          testsRun++;
          if (cyc - 1 !== latOf(d)) begin
            testsFailed++;
            $display("[TB] FAIL dut%0d first_resp_latency: got %0d expected %0d", d, cyc - 1, latOf(d));
          end
        end
        if (beat == dropAt) begin
          memRead[d]  = 1'b0;
          memWrite[d] = 1'b0;
          done = 1'b1;
        end else begin
          if (isWrite) begin
            memWdata[d] = data[64*beat +: 64];
            model[d][idx][64*beat +: 64] = data[64*beat +: 64];
          end else begin
            expBeat = expQ.pop_front();
            testsRun++;
            if (memRdata[d] !== expBeat) begin
              testsFailed++;
              $display("[TB] FAIL dut%0d rdata addr %h beat %0d: got %h expected %h",
                       d, addr, beat, memRdata[d], expBeat);
            end
          end
          beat++;
          if (beat == 4) done = 1'b1;
        end
      end
    end
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL dut%0d burst_timeout addr %h: got %0d beats expected %0d", d, addr, beat, dropAt);
      expQ.delete();
    end
    @(negedge clk);
    testsRun++;
    if (memResp[d] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL dut%0d resp_after_burst: got %b expected 0", d, memResp[d]);
    end
    testsRun++;
    if (protoErr[d] !== ((dropAt < 4) ? 1'b1 : 1'b0)) begin
      testsFailed++;
      $display("[TB] FAIL dut%0d proto_err_end: got %b expected %b", d, protoErr[d], dropAt < 4);
    end
    memRead[d]  = 1'b0;
    memWrite[d] = 1'b0;
    @(negedge clk);
    testsRun++;
    if (protoErr[d] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL dut%0d proto_err_one_cycle: got %b expected 0", d, protoErr[d]);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      testsRun++;
      if (memResp[d] !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL dut%0d reset_resp: got %b expected 0", d, memResp[d]);
      end
      testsRun++;
      if (memRdata[d] !== 64'd0) begin
        testsFailed++;
        $display("[TB] FAIL dut%0d reset_rdata: got %h expected 0", d, memRdata[d]);
      end
      testsRun++;
      if (protoErr[d] !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL dut%0d reset_proto_err: got %b expected 0", d, protoErr[d]);
      end
    end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    doBurst(0, 1'b1, 32'h0000_0100,
            {64'hA3A3_0003_3333_A3A3, 64'hA2A2_0002_2222_A2A2,
             64'hA1A1_0001_1111_A1A1, 64'hA0A0_0000_0000_A0A0}, 4);
    doBurst(0, 1'b0, 32'h0000_0100, '0, 4);
  endtask

  task automatic test_offset_ignored();
    doBurst(0, 1'b0, 32'h0000_011F, '0, 4);
  endtask

  task automatic test_alias();
    doBurst(0, 1'b1, 32'h0000_2000, randLine(), 4);
    doBurst(0, 1'b0, 32'h0000_0000, '0, 4);
  endtask

  task automatic test_both_high();
    memAddr[0]  = 32'h0000_0100;
    memWdata[0] = 64'hDEAD_BEEF_DEAD_BEEF;
    memRead[0]  = 1'b1;
    memWrite[0] = 1'b1;
    @(negedge clk);
    testsRun++;
    if (protoErr[0] !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL both_high_proto_err: got %b expected 1", protoErr[0]);
    end
    memRead[0]  = 1'b0;
    memWrite[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      testsRun++;
      if (memResp[0] !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL both_high_resp cycle %0d: got %b expected 0", i, memResp[0]);
      end
      @(negedge clk);
    end
    testsRun++;
    if (protoErr[0] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL both_high_proto_err_clear: got %b expected 0", protoErr[0]);
    end
    doBurst(0, 1'b0, 32'h0000_0100, '0, 4);
  endtask

  task automatic test_write_abort();
    doBurst(0, 1'b1, 32'h0000_0100, randLine(), 2);
    doBurst(0, 1'b0, 32'h0000_0100, '0, 4);
  endtask

  task automatic test_read_abort();
    doBurst(0, 1'b0, 32'h0000_0100, '0, 1);
  endtask

  task automatic test_reset_in_wait();
    memAddr[0] = 32'h0000_0100;
    memRead[0] = 1'b1;
    repeat (2) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    testsRun++;
    if (memResp[0] !== 1'b0 || memRdata[0] !== 64'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_in_wait: got resp %b rdata %h expected resp 0 rdata 0", memResp[0], memRdata[0]);
    end
    resetN = 1'b1;
    memRead[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      testsRun++;
      if (memResp[0] !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset_in_wait_quiet cycle %0d: got %b expected 0", i, memResp[0]);
      end
    end
    doBurst(0, 1'b0, 32'h0000_0100, '0, 4);
  endtask

  task automatic test_latency1();
    doBurst(1, 1'b1, 32'h0000_0340, randLine(), 4);
    doBurst(1, 1'b0, 32'h0000_0340, '0, 4);
    doBurst(1, 1'b1, 32'h0001_0340, randLine(), 4);
    doBurst(1, 1'b0, 32'h0000_035C, '0, 4);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    for (int i = 0; i < 4; i++) begin
      addrs[i] = (($urandom_range(0, 15)) << 13) | ((i * 37 + 3) << 5) | $urandom_range(0, 31);
      doBurst(0, 1'b1, addrs[i], randLine(), 4);
    end
    for (int i = 3; i >= 0; i--) doBurst(0, 1'b0, addrs[i], '0, 4);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      memRead[d]  = 1'b0;
      memWrite[d] = 1'b0;
      memAddr[d]  = '0;
      memWdata[d] = '0;
    end
    resetN = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_offset_ignored();
    test_alias();
    test_both_high();
    test_write_abort();
    test_read_abort();
    test_reset_in_wait();
    test_latency1();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
